// File: rtl/filter_sample_feeder.sv
// Sample feeder for the FIR filter: FIFO buffering, priming, paced single-cycle issue.
// Optional statistics counters are built when FILTER_SAMPLE_FEEDER_STATS_EN is defined.
module filter_sample_feeder #(
   parameter int Depth      = 16,
   parameter int AddrWidth  = 4,
   parameter int DataWidth  = 2,
   parameter int DivWidth   = 8,
   parameter int PrimeLevel = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 enable_i,
   input  logic                 flush_i,
   input  logic [DivWidth-1:0]  rate_div_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [DataWidth-1:0] in_data_i,
   output logic                 data_in_req_o,
   output logic [DataWidth-1:0] data_in_o,
   output logic [AddrWidth:0]   fill_o,
   output logic                 underrun_o,
   output logic [15:0]          issue_cnt_o,
   output logic [15:0]          underrun_cnt_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN} state_e;

   localparam logic [AddrWidth:0]   FILL_MAX  = (AddrWidth+1)'(Depth);
   localparam logic [AddrWidth:0]   FILL_PRIM = (AddrWidth+1)'(PrimeLevel);
   localparam logic [AddrWidth:0]   FILL_ONE  = 1;
   localparam logic [AddrWidth-1:0] PTR_ONE   = 1;
   localparam logic [DivWidth-1:0]  DIV_ONE   = 1;

   state_e                state_q, state_d;
   logic [DataWidth-1:0]  mem [Depth];
   logic [AddrWidth-1:0]  wr_ptr_q, rd_ptr_q;
   logic [AddrWidth:0]    fill_q;
   logic [DivWidth-1:0]   pace_cnt_q, pace_cnt_d;
   logic                  tick, push, pop, empty_tick;

   assign in_ready_o = (fill_q < FILL_MAX);
   assign fill_o     = fill_q;

   always_comb begin
      tick       = (state_q == ST_RUN) && enable_i && (pace_cnt_q == '0);
      push       = in_valid_i && in_ready_o && !flush_i;
      pop        = tick && (fill_q != '0) && !flush_i;
      empty_tick = tick && (fill_q == '0) && !flush_i;

      state_d = state_q;
      if (flush_i) begin
         state_d = enable_i ? ST_PRIME : ST_IDLE;
      end else if (!enable_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE:  state_d = ST_PRIME;
            ST_PRIME: if (fill_q >= FILL_PRIM) state_d = ST_RUN;
            ST_RUN:   if (empty_tick) state_d = ST_PRIME;
            default:  state_d = ST_IDLE;
         endcase
      end

      // Counter only runs while RUN persists; any other path parks it at 0 so RUN starts with a tick.
      pace_cnt_d = '0;
      if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
         pace_cnt_d = (pace_cnt_q == '0) ? rate_div_i : (pace_cnt_q - DIV_ONE);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         fill_q        <= '0;
         pace_cnt_q    <= '0;
         data_in_req_o <= 1'b0;
         data_in_o     <= '0;
         underrun_o    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pace_cnt_q    <= pace_cnt_d;
         data_in_req_o <= pop;
         underrun_o    <= empty_tick;
         if (pop) data_in_o <= mem[rd_ptr_q];
         if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
               2'b10:   fill_q <= fill_q + FILL_ONE;
               2'b01:   fill_q <= fill_q - FILL_ONE;
               default: fill_q <= fill_q;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) mem[wr_ptr_q] <= in_data_i;
   end

`ifdef FILTER_SAMPLE_FEEDER_STATS_EN
   logic [15:0] issue_cnt_q, underrun_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issue_cnt_q    <= '0;
         underrun_cnt_q <= '0;
      end else if (flush_i) begin
         issue_cnt_q    <= '0;
         underrun_cnt_q <= '0;
      end else begin
         if (data_in_req_o && (issue_cnt_q != 16'hFFFF)) issue_cnt_q <= issue_cnt_q + 16'd1;
         if (underrun_o && (underrun_cnt_q != 16'hFFFF)) underrun_cnt_q <= underrun_cnt_q + 16'd1;
      end
   end

   assign issue_cnt_o    = issue_cnt_q;
   assign underrun_cnt_o = underrun_cnt_q;
`else
   assign issue_cnt_o    = '0;
   assign underrun_cnt_o = '0;
`endif

endmodule

// File: doc/filter_sample_feeder.md
Name: filter_sample_feeder

Overview:
- Upstream stage of the FIR filter (Order 127, AddrWidth 7). Buffers bursty 2-bit samples from a valid/ready source in a small FIFO.
- Issues them to the filter as single-cycle requests at a programmable pacing rate.
- Primes the FIFO before streaming. Flags underruns when a pacing tick finds the FIFO empty.

Parameters:
- Depth, 16, FIFO entries (power of two, >= 2).
- AddrWidth, 4, log2(Depth).
- DataWidth, 2, sample width; must match filter data input.
- DivWidth, 8, width of pacing divider.
- PrimeLevel, 8, FIFO fill required before streaming (1..Depth).

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- enable_i  in  1  streaming enable.
- flush_i  in  1  synchronous FIFO/pacer clear.
- rate_div_i  in  DivWidth  pacing: one tick every rate_div_i+1 cycles.
- in_valid_i  in  1  upstream sample valid.
- in_ready_o  out  1  FIFO can accept.
- in_data_i  in  DataWidth  upstream sample.
- data_in_req_o  out  1  one-cycle request to the filter.
- data_in_o  out  DataWidth  sample to the filter; valid when req high.
- fill_o  out  AddrWidth+1  current FIFO occupancy.
- underrun_o  out  1  one-cycle pulse on tick with empty FIFO in RUN.
- issue_cnt_o  out  16  issued-sample count (optional feature).
- underrun_cnt_o  out  16  underrun count (optional feature).

Behaviour:
- Reset values:
  - state=IDLE; fill_o=0; in_ready_o=1.
  - data_in_req_o=0; data_in_o=0; underrun_o=0.
  - pacing counter=0; stats counters=0.
- FIFO:
  - Push when in_valid_i && in_ready_o && !flush_i.
  - in_ready_o = (fill < Depth). It does not depend on a same-cycle pop, so a full FIFO refuses a push even in a pop cycle.
  - Pop uses the cycle-start occupancy; no bypass. A sample pushed in cycle t is poppable at t+1 at the earliest.
  - Simultaneous push and pop leaves fill unchanged. Pointers wrap modulo Depth.
- Pacer:
  - Down-counter. A tick fires when the counter is 0 and state is RUN; the counter then reloads rate_div_i.
  - rate_div_i=0 gives a tick every cycle.
  - rate_div_i is sampled only at reload. A mid-period change takes effect after the current period.
  - Outside RUN the counter is held at 0, so the first tick is on the first RUN cycle.
- FSM:
  - IDLE: wait for enable_i=1, then go to PRIME.
  - PRIME: no requests. Go to RUN once fill >= PrimeLevel (evaluated on registered fill).
  - RUN:
    - Tick with fill>0: pop. Next cycle data_in_req_o=1 and data_in_o=popped sample (registered; latency 1 cycle from tick).
    - Tick with fill==0: underrun_o=1 next cycle, no request, go to PRIME.
  - Any state with enable_i=0: go to IDLE next cycle. An in-flight registered request still completes; no new pops. FIFO contents are retained and pushes are still accepted.
- flush_i (priority over push/pop):
  - Next cycle: fill=0, pointers=0, counter=0, no request.
  - State goes to PRIME if enable_i, else IDLE.
- data_in_o holds its last value when req is low.
- Asynchronous reset mid-operation returns all registers to reset values immediately. No request is emitted after reset deasserts until PRIME completes.

Optional Feature:
- Macro: FILTER_SAMPLE_FEEDER_STATS_EN.
- Defined:
  - issue_cnt_o increments on each data_in_req_o=1 cycle; underrun_cnt_o increments on each underrun_o pulse.
  - Both are 16-bit, saturating at 16'hFFFF, and cleared by reset and flush_i.
- Undefined: ports remain; both outputs tied to 0; no counter logic.

Test Plan:
- Reset / prime / stream:
  - Stimulus: reset, then enable_i=1, rate_div_i=0, push 8 samples 0,1,2,3,0,1,2,3 back-to-back.
  - Response: PRIME until fill=8. Then 8 consecutive req pulses with data 0,1,2,3,0,1,2,3. Then underrun_o pulse and return to PRIME.
- Pacing:
  - Stimulus: rate_div_i=3, FIFO pre-filled to 16, enable.
  - Response: req spacing exactly 4 cycles. Changing rate_div_i to 1 mid-period gives one more 4-cycle gap, then 2-cycle gaps.
- Full boundary:
  - Stimulus: enable_i=0, push 20 valid samples.
  - Response: in_ready_o drops after 16th accept; fill_o=16; samples 17-20 held off. Enable and pop once: in_ready_o=1 the next cycle.
- Flush:
  - Stimulus: fill=10 in RUN; assert flush_i together with in_valid_i=1.
  - Response: next cycle fill_o=0, no req, state PRIME; flushed-cycle push discarded.
- Async reset mid-stream:
  - Stimulus: drop rst_ni during RUN with fill=5.
  - Response: req=0 and fill_o=0 immediately. No req until 8 new samples are pushed.
- Stats (macro defined):
  - Stimulus: 3 issued samples and 2 underruns.
  - Response: issue_cnt_o=3, underrun_cnt_o=2. Macro undefined: both read 0.
